// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter: round-robin arbiter with a one-hot rotating priority
// pointer, a registered one-hot grant, and a per-grant hold-time limit.
// Every grant is followed by at least one IDLE cycle.
module ring_rr_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] done,
  output logic [N-1:0] grant,
  output logic         busy,
  output logic [N-1:0] ptr,
  output logic         timeout
);

  localparam int unsigned CW = $clog2(MAX_HOLD);
  localparam logic [N-1:0]  ONE       = N'(1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  ptr_q, ptr_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          timeout_q, timeout_d;

  logic [N-1:0]  masked;
  logic [N-1:0]  pick;
  logic          rel_done, rel_req, rel_hold, rel;

  // Circular priority pick: requests at or above the pointer win first,
  // otherwise wrap to the lowest set request. x & -x isolates the lowest bit.
  always_comb begin
    masked = req & ~(ptr_q - ONE);
    if (masked != '0) begin
      pick = masked & (~masked + ONE);
    end else begin
      pick = req & (~req + ONE);
    end
  end

  // Release conditions, qualified by the current owner's bit only.
  always_comb begin
    rel_done = |(done & grant_q);
    rel_req  = ~|(req & grant_q);
    rel_hold = (hold_q == HOLD_LAST);
    rel      = rel_done | rel_req | rel_hold;
  end

  // Next-state and next-output logic for the IDLE/GRANT FSM.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        hold_d  = '0;
        if (req != '0) begin
          grant_d = pick;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (rel) begin
          grant_d   = '0;
          hold_d    = '0;
          state_d   = S_IDLE;
          ptr_d     = {grant_q[N-2:0], grant_q[N-1]};
          timeout_d = rel_hold & ~rel_done & ~rel_req;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      ptr_q     <= ONE;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign ptr     = ptr_q;
  assign busy    = (state_q == S_GRANT);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed testbench for ring_rr_arbiter (N=4, MAX_HOLD=8).
module tb_ring_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic       busy;
  logic [3:0] ptr;
  logic       timeout;

  int checks;
  int failures;

  ring_rr_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .done   (done),
    .grant  (grant),
    .busy   (busy),
    .ptr    (ptr),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    done = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (grant !== 4'b0000 || ptr !== 4'b0001 || busy !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_init grant=%b ptr=%b busy=%b to=%b required 0000/0001/0/0", grant, ptr, busy, timeout);
    end
    req = 4'b0010;
    tick();
    checks++;
    if (grant !== 4'b0010 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_pregrant grant=%b busy=%b required 0010/1", grant, busy);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0000 || ptr !== 4'b0001 || busy !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_async grant=%b ptr=%b busy=%b to=%b required 0000/0001/0/0", grant, ptr, busy, timeout);
    end
    req = '0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g;
    logic [3:0] exp_p;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      exp_g = 4'b0001 << i;
      exp_p = 4'b0001 << ((i + 1) % 4);
      tick();
      checks++;
      if (grant !== exp_g || busy !== 1'b1) begin
        failures++;
        $display("FAIL rot_grant%0d grant=%b busy=%b required %b/1", i, grant, busy, exp_g);
      end
      done = exp_g;
      tick();
      done = '0;
      checks++;
      if (grant !== 4'b0000 || ptr !== exp_p || timeout !== 1'b0) begin
        failures++;
        $display("FAIL rot_release%0d grant=%b ptr=%b to=%b required 0000/%b/0", i, grant, ptr, timeout, exp_p);
      end
    end
    tick();
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL rot_wrap grant=%b required 0001", grant);
    end
    req = '0;
    tick();
  endtask

  task automatic test_skip_wrap();
    do_reset();
    req = 4'b0100;
    tick();
    checks++;
    if (grant !== 4'b0100) begin
      failures++;
      $display("FAIL skip_grant grant=%b required 0100", grant);
    end
    done = 4'b0100;
    tick();
    done = '0;
    checks++;
    if (grant !== 4'b0000 || ptr !== 4'b1000) begin
      failures++;
      $display("FAIL skip_release grant=%b ptr=%b required 0000/1000", grant, ptr);
    end
    req = 4'b0001;
    tick();
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL wrap_grant grant=%b required 0001", grant);
    end
    done = 4'b0001;
    tick();
    done = '0;
    req  = '0;
    checks++;
    if (grant !== 4'b0000 || ptr !== 4'b0010) begin
      failures++;
      $display("FAIL wrap_release grant=%b ptr=%b required 0000/0010", grant, ptr);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0010;
    tick();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (grant !== 4'b0010 || timeout !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d grant=%b to=%b required 0010/0", k, grant, timeout);
      end
      tick();
    end
    checks++;
    if (grant !== 4'b0000 || timeout !== 1'b1 || ptr !== 4'b0100 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_release grant=%b to=%b ptr=%b busy=%b required 0000/1/0100/0", grant, timeout, ptr, busy);
    end
    tick();
    checks++;
    if (grant !== 4'b0010 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_regrant grant=%b to=%b required 0010/0", grant, timeout);
    end
    req = '0;
    tick();
    checks++;
    if (grant !== 4'b0000 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL drop_no_timeout grant=%b to=%b required 0000/0", grant, timeout);
    end
  endtask

  task automatic test_drop_foreign();
    do_reset();
    req = 4'b0001;
    tick();
    done = 4'b1000;
    tick();
    done = '0;
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL foreign_done grant=%b required 0001", grant);
    end
    tick();
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL third_cycle grant=%b required 0001", grant);
    end
    req = '0;
    tick();
    checks++;
    if (grant !== 4'b0000 || timeout !== 1'b0 || ptr !== 4'b0010) begin
      failures++;
      $display("FAIL req_drop grant=%b to=%b ptr=%b required 0000/0/0010", grant, timeout, ptr);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    checks++;
    if (grant !== 4'b0100) begin
      failures++;
      $display("FAIL midrst_pre grant=%b required 0100", grant);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0000 || ptr !== 4'b0001 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async grant=%b ptr=%b to=%b required 0000/0001/0", grant, ptr, timeout);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b0100 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL midrst_regrant grant=%b to=%b required 0100/0", grant, timeout);
    end
    req = '0;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req      = '0;
    done     = '0;
    #2;
    test_reset();
    test_rotation();
    test_skip_wrap();
    test_timeout();
    test_drop_foreign();
    test_reset_mid_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
